// File: rtl/counter_seek_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_seek_ctrl
//  Brief    : Drives the inc/dec strobes of a modulo-M up/down counter so the
//             counter reaches a requested target along the shortest
//             wrap-around path. One request at a time is taken through a
//             valid/ready handshake, and cnt is sampled once at accept.
//             Optional feature macro: SEEK_RATE_EN. It adds the rate port
//             and a GAP state that inserts idle cycles between steps.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_seek_ctrl #(
    parameter int M      = 13,
    parameter int B      = $clog2(M),
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [B-1:0]      req_target,
    output logic              req_ready,
    input  logic              abort,
`ifdef SEEK_RATE_EN
    input  logic [RATE_W-1:0] rate,
`endif
    input  logic [B-1:0]      cnt,
    output logic              inc,
    output logic              dec,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_MOVE = 3'd1;
    localparam logic [2:0] c_ST_DONE = 3'd2;
    localparam logic [2:0] c_ST_ERR  = 3'd3;
`ifdef SEEK_RATE_EN
    localparam logic [2:0] c_ST_GAP  = 3'd4;
`endif

    // Modulus extended by one bit so that target + M - cnt cannot overflow.
    localparam logic [B:0]   c_MOD     = (B+1)'(M);
    localparam logic [B-1:0] c_REM_ONE = B'(1);
`ifdef SEEK_RATE_EN
    localparam logic [RATE_W-1:0] c_GAP_ONE = RATE_W'(1);
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [B-1:0]      r_remaining;
    logic              r_dir_up;
`ifdef SEEK_RATE_EN
    logic [RATE_W-1:0] r_rate;
    logic [RATE_W-1:0] r_gap_cnt;
`endif

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [2:0]        w_state_nxt;
    logic              w_accept;
    logic [B:0]        w_tgt_ext;
    logic [B:0]        w_cnt_ext;
    logic [B:0]        w_up;
    logic [B:0]        w_down;
    logic              w_dir_up;
    logic [B:0]        w_dist;
    logic              w_tgt_bad;

    assign w_accept  = (r_state == c_ST_IDLE) && req_valid;
    assign w_tgt_ext = {1'b0, req_target};
    assign w_cnt_ext = {1'b0, cnt};
    assign w_tgt_bad = (w_tgt_ext >= c_MOD);

    // Shortest wrap-around distance; a tie on even M goes up.
    always_comb begin
        w_up     = '0;
        w_down   = '0;
        w_dir_up = 1'b1;
        w_dist   = '0;
        if (req_target >= cnt) begin
            w_up = w_tgt_ext - w_cnt_ext;
        end else begin
            w_up = w_tgt_ext + c_MOD - w_cnt_ext;
        end
        if (w_up != '0) begin
            w_down = c_MOD - w_up;
        end
        w_dir_up = (w_up <= w_down);
        w_dist   = w_dir_up ? w_up : w_down;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort takes priority over completion in MOVE/GAP.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    if (w_tgt_bad) begin
                        w_state_nxt = c_ST_ERR;
                    end else if (w_dist == '0) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_MOVE;
                    end
                end
            end
            c_ST_MOVE: begin
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_remaining == c_REM_ONE) begin
                    w_state_nxt = c_ST_DONE;
`ifdef SEEK_RATE_EN
                end else if (r_rate != '0) begin
                    w_state_nxt = c_ST_GAP;
`endif
                end else begin
                    w_state_nxt = c_ST_MOVE;
                end
            end
`ifdef SEEK_RATE_EN
            c_ST_GAP: begin
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_gap_cnt == c_GAP_ONE) begin
                    w_state_nxt = c_ST_MOVE;
                end else begin
                    w_state_nxt = c_ST_GAP;
                end
            end
`endif
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            c_ST_ERR:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Seek context: distance and direction latched at accept, counted down per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_dir_up    <= 1'b1;
        end else if (w_accept) begin
            r_remaining <= w_tgt_bad ? '0 : B'(w_dist);
            r_dir_up    <= w_dir_up;
        end else if (r_state == c_ST_MOVE) begin
            r_remaining <= r_remaining - c_REM_ONE;
        end
    end

`ifdef SEEK_RATE_EN
    // Gap pacing: rate latched at accept; the gap counter is primed on every
    // step so that it holds the full rate when GAP is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rate    <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_rate <= rate;
            end
            if (r_state == c_ST_MOVE) begin
                r_gap_cnt <= r_rate;
            end else if (r_state == c_ST_GAP) begin
                r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
            end
        end
    end
`endif

    // Moore outputs decoded from the registered state only.
    always_comb begin
        req_ready = (r_state == c_ST_IDLE);
        busy      = (r_state != c_ST_IDLE);
        inc       = (r_state == c_ST_MOVE) &&  r_dir_up;
        dec       = (r_state == c_ST_MOVE) && !r_dir_up;
        done      = (r_state == c_ST_DONE);
        err       = (r_state == c_ST_ERR);
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_seek_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_seek_ctrl
//  Brief    : Directed bench for counter_seek_ctrl. Two instances (M=13 and
//             M=12) each drive a simple modulo counter; per-cycle traces of
//             the strobes and status are compared with hand-derived masks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seek_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_target;
    logic       abort;
`ifdef SEEK_RATE_EN
    logic [7:0] rate;
`endif
    logic       ld;
    logic [3:0] ld_val;

    logic [3:0] cnt13, cnt12;
    logic       rdy13, inc13, dec13, busy13, done13, err13;
    logic       rdy12, inc12, dec12, busy12, done12, err12;

    int         n_checks = 0;
    int         n_fail   = 0;

    // Per-cycle traces of the selected instance, cycle 0 = accept cycle.
    logic [15:0] tr_inc, tr_dec, tr_done, tr_err, tr_rdy, tr_busy;
    int          tr_cnt [16];

    always #5 clk = ~clk;

    counter_seek_ctrl #(.M(13)) dut13 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_ready  (rdy13),
        .abort      (abort),
`ifdef SEEK_RATE_EN
        .rate       (rate),
`endif
        .cnt        (cnt13),
        .inc        (inc13),
        .dec        (dec13),
        .busy       (busy13),
        .done       (done13),
        .err        (err13)
    );

    counter_seek_ctrl #(.M(12)) dut12 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_ready  (rdy12),
        .abort      (abort),
`ifdef SEEK_RATE_EN
        .rate       (rate),
`endif
        .cnt        (cnt12),
        .inc        (inc12),
        .dec        (dec12),
        .busy       (busy12),
        .done       (done12),
        .err        (err12)
    );

    // Controlled counters: modulo 13 and modulo 12, loadable by the bench.
    always @(posedge clk) begin
        if (ld) begin
            cnt13 <= ld_val;
            cnt12 <= ld_val;
        end else begin
            if (inc13)      cnt13 <= (cnt13 == 4'd12) ? 4'd0  : cnt13 + 4'd1;
            else if (dec13) cnt13 <= (cnt13 == 4'd0)  ? 4'd12 : cnt13 - 4'd1;
            if (inc12)      cnt12 <= (cnt12 == 4'd11) ? 4'd0  : cnt12 + 4'd1;
            else if (dec12) cnt12 <= (cnt12 == 4'd0)  ? 4'd11 : cnt12 - 4'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One seek: reset both instances, load the counters, request in cycle 0,
    // then trace 16 cycles. abort/rst are raised in the given cycle (-1 = none).
    task automatic run_seek(input bit sel12, input int start, input int tgt,
                            input int rate_v, input int abort_cyc, input int rst_cyc);
        @(posedge clk); #1;
        rst = 1'b1; ld = 1'b1; ld_val = 4'(start);
        @(posedge clk); #1;
        rst = 1'b0; ld = 1'b0;
        req_valid  = 1'b1;
        req_target = 4'(tgt);
`ifdef SEEK_RATE_EN
        rate = 8'(rate_v);
`else
        if (rate_v != 0) $display("note: rate ignored in this build");
`endif
        for (int c = 0; c < 16; c++) begin
            if (c == 1) req_valid = 1'b0;
            abort = (c == abort_cyc);
            rst   = (c == rst_cyc);
            @(negedge clk);
            tr_inc[c]  = sel12 ? inc12  : inc13;
            tr_dec[c]  = sel12 ? dec12  : dec13;
            tr_done[c] = sel12 ? done12 : done13;
            tr_err[c]  = sel12 ? err12  : err13;
            tr_rdy[c]  = sel12 ? rdy12  : rdy13;
            tr_busy[c] = sel12 ? busy12 : busy13;
            tr_cnt[c]  = sel12 ? int'(cnt12) : int'(cnt13);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b1; ld_val = 4'd0;
        req_valid = 1'b0; req_target = 4'd0; abort = 1'b0;
`ifdef SEEK_RATE_EN
        rate = 8'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; ld = 1'b0;
        @(negedge clk);
        check_eq("reset13", {rdy13, busy13, inc13, dec13, done13, err13}, 32'b100000);
        check_eq("reset12", {rdy12, busy12, inc12, dec12, done12, err12}, 32'b100000);

        // M=13, 3 -> 5: two incs, done in cycle 3, ready again in cycle 4.
        run_seek(1'b0, 3, 5, 0, -1, -1);
        check_eq("up2_inc",  tr_inc,  16'h0006);
        check_eq("up2_dec",  tr_dec,  16'h0000);
        check_eq("up2_done", tr_done, 16'h0008);
        check_eq("up2_rdy",  tr_rdy,  16'hFFF1);
        check_eq("up2_cnt",  tr_cnt[3], 5);

        // M=13, 2 -> 11: four decs wrapping through 0 to 12 then 11.
        run_seek(1'b0, 2, 11, 0, -1, -1);
        check_eq("dn4_dec",  tr_dec,  16'h001E);
        check_eq("dn4_inc",  tr_inc,  16'h0000);
        check_eq("dn4_done", tr_done, 16'h0020);
        check_eq("dn4_wrap", tr_cnt[4], 12);
        check_eq("dn4_cnt",  tr_cnt[5], 11);

        // M=12, 0 -> 6: tie resolves up, six incs.
        run_seek(1'b1, 0, 6, 0, -1, -1);
        check_eq("tie_inc",  tr_inc,  16'h007E);
        check_eq("tie_dec",  tr_dec,  16'h0000);
        check_eq("tie_done", tr_done, 16'h0080);
        check_eq("tie_cnt",  tr_cnt[7], 6);

        // M=12, 7 -> 7: zero distance, done in cycle 1, ready in cycle 2.
        run_seek(1'b1, 7, 7, 0, -1, -1);
        check_eq("zero_stb",  tr_inc | tr_dec, 16'h0000);
        check_eq("zero_done", tr_done, 16'h0002);
        check_eq("zero_rdy",  tr_rdy,  16'hFFFD);

        // M=13, targets 13 and 15 rejected.
        run_seek(1'b0, 4, 13, 0, -1, -1);
        check_eq("e13_err", tr_err, 16'h0002);
        check_eq("e13_stb", tr_inc | tr_dec | tr_done, 16'h0000);
        check_eq("e13_cnt", tr_cnt[2], 4);
        run_seek(1'b0, 4, 15, 0, -1, -1);
        check_eq("e15_err", tr_err, 16'h0002);
        check_eq("e15_rdy", tr_rdy, 16'hFFFD);

        // M=13, 0 -> 5, abort in cycle 3: strobes 1..3, idle in 4, cnt=3.
        run_seek(1'b0, 0, 5, 0, 3, -1);
        check_eq("abt_inc",  tr_inc,  16'h000E);
        check_eq("abt_done", tr_done, 16'h0000);
        check_eq("abt_rdy",  tr_rdy,  16'hFFF1);
        check_eq("abt_cnt",  tr_cnt[4], 3);

        // Same seek, reset in cycle 2: idle with reset outputs in cycle 3.
        run_seek(1'b0, 0, 5, 0, -1, 2);
        check_eq("rst_inc",  tr_inc,  16'h0006);
        check_eq("rst_done", tr_done, 16'h0000);
        check_eq("rst_outs", {tr_rdy[3], tr_busy[3], tr_inc[3], tr_dec[3], tr_done[3], tr_err[3]}, 32'b100000);

`ifdef SEEK_RATE_EN
        // rate=2, 0 -> 3: incs in cycles 1, 4, 7 and done in cycle 8.
        run_seek(1'b0, 0, 3, 2, -1, -1);
        check_eq("gap_inc",  tr_inc,  16'h0092);
        check_eq("gap_done", tr_done, 16'h0100);
        check_eq("gap_rdy",  tr_rdy,  16'hFE01);
        check_eq("gap_cnt",  tr_cnt[8], 3);
        // rate=0 behaves like back-to-back stepping.
        run_seek(1'b0, 0, 3, 0, -1, -1);
        check_eq("r0_inc",  tr_inc,  16'h000E);
        check_eq("r0_done", tr_done, 16'h0010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
